// File: rtl/wait_state_data_memory.sv
// Single-port word memory with configurable wait states and a MemReady pulse.
// Ports: InputClk, rst (async high), ControlBus/AddressBus/DataBusOut in,
//        DataBusIn, MemReady, ReadCount, WriteCount, StallCycles, BusError out.
module wait_state_data_memory #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  InputClk,
    input  logic                  rst,
    input  logic [2:0]            ControlBus,
    input  logic [ADDR_WIDTH-1:0] AddressBus,
    input  logic [DATA_WIDTH-1:0] DataBusOut,
    output logic [DATA_WIDTH-1:0] DataBusIn,
    output logic                  MemReady,
    output logic [CNT_WIDTH-1:0]  ReadCount,
    output logic [CNT_WIDTH-1:0]  WriteCount,
    output logic [CNT_WIDTH-1:0]  StallCycles,
    output logic                  BusError
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t state;
    logic [3:0] waitCnt;
    logic latWrite;
    logic [IDX_W-1:0] latIdx;
    logic [DATA_WIDTH-1:0] latData;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic reqWr;
    logic reqRd;
    logic reqValid;
    logic reqBoth;
    logic [IDX_W-1:0] busIdx;

    assign reqWr    = ControlBus[2] & ~ControlBus[1];
    assign reqRd    = ControlBus[1] & ~ControlBus[2];
    assign reqValid = reqWr | reqRd;
    assign reqBoth  = ControlBus[2] & ControlBus[1];
    assign busIdx   = AddressBus[IDX_W-1:0];

    // Reserved control bit and aliased upper address bits are ignored.
    logic unusedBits;
    assign unusedBits = ^{ControlBus[0], AddressBus[ADDR_WIDTH-1:IDX_W]};

    // The access itself happens on the edge entering DONE. With no wait
    // states that edge is the sampling edge, so bus values are used directly.
    logic doAccess;
    logic accWrite;
    logic [IDX_W-1:0] accIdx;
    logic [DATA_WIDTH-1:0] accData;

    always_comb begin
        doAccess = 1'b0;
        accWrite = latWrite;
        accIdx   = latIdx;
        accData  = latData;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (WAIT_STATES == 0 && reqValid) begin
                        doAccess = 1'b1;
                        accWrite = reqWr;
                        accIdx   = busIdx;
                        accData  = DataBusOut;
                    end
                end
                WAIT: doAccess = (waitCnt == 4'd1);
                default: doAccess = 1'b0;
            endcase
        end
    end

    function automatic logic [CNT_WIDTH-1:0] satInc(
        input logic [CNT_WIDTH-1:0] v
    );
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Array has no reset: contents survive rst.
    always_ff @(posedge InputClk) begin
        if (doAccess && accWrite)
            mem[accIdx] <= accData;
    end

    always_ff @(posedge InputClk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            waitCnt     <= '0;
            latWrite    <= 1'b0;
            latIdx      <= '0;
            latData     <= '0;
            DataBusIn   <= '0;
            MemReady    <= 1'b0;
            ReadCount   <= '0;
            WriteCount  <= '0;
            StallCycles <= '0;
            BusError    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (reqBoth) begin
                        BusError <= 1'b1;
                    end else if (reqValid) begin
                        latWrite <= reqWr;
                        latIdx   <= busIdx;
                        latData  <= DataBusOut;
                        if (WAIT_STATES > 0) begin
                            state   <= WAIT;
                            waitCnt <= WS;
                        end
                    end
                end
                WAIT: begin
                    StallCycles <= satInc(StallCycles);
                    waitCnt     <= waitCnt - 4'd1;
                end
                DONE: begin
                    MemReady  <= 1'b0;
                    DataBusIn <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (doAccess) begin
                state    <= DONE;
                MemReady <= 1'b1;
                if (accWrite) begin
                    WriteCount <= satInc(WriteCount);
                end else begin
                    ReadCount <= satInc(ReadCount);
                    DataBusIn <= mem[accIdx];
                end
            end
        end
    end

endmodule

// File: tb/tb_wait_state_data_memory.sv
// Directed bench: three instances (2 wait states, 0 wait states,
// 4-bit counters with 1 wait state) driven from negedge, sampled at negedge.
module tb_wait_state_data_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [3];
    logic [2:0]  ctrl [3];
    logic [31:0] addr [3];
    logic [31:0] dout [3];
    logic [31:0] din  [3];
    logic        rdy  [3];
    logic        be   [3];
    logic [31:0] rc0, wc0, sc0, rc1, wc1, sc1;
    logic [3:0]  rc2, wc2, sc2;

    int lat [3] = '{3, 1, 2};
    int checks = 0;
    int errors = 0;

    wait_state_data_memory #(.WAIT_STATES(2)) dut0 (
        .InputClk(clk), .rst(rst[0]), .ControlBus(ctrl[0]),
        .AddressBus(addr[0]), .DataBusOut(dout[0]), .DataBusIn(din[0]),
        .MemReady(rdy[0]), .ReadCount(rc0), .WriteCount(wc0),
        .StallCycles(sc0), .BusError(be[0])
    );

    wait_state_data_memory #(.WAIT_STATES(0)) dut1 (
        .InputClk(clk), .rst(rst[1]), .ControlBus(ctrl[1]),
        .AddressBus(addr[1]), .DataBusOut(dout[1]), .DataBusIn(din[1]),
        .MemReady(rdy[1]), .ReadCount(rc1), .WriteCount(wc1),
        .StallCycles(sc1), .BusError(be[1])
    );

    wait_state_data_memory #(.WAIT_STATES(1), .CNT_WIDTH(4)) dut2 (
        .InputClk(clk), .rst(rst[2]), .ControlBus(ctrl[2]),
        .AddressBus(addr[2]), .DataBusOut(dout[2]), .DataBusIn(din[2]),
        .MemReady(rdy[2]), .ReadCount(rc2), .WriteCount(wc2),
        .StallCycles(sc2), .BusError(be[2])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    // Issue one access on instance d from a negedge, hold it until MemReady,
    // and check MemReady/DataBusIn every cycle through the return to IDLE.
    task automatic access(input int d, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rexp,
                          input string tag);
        ctrl[d] = wr ? 3'b100 : 3'b010;
        addr[d] = a;
        dout[d] = wd;
        for (int k = 1; k <= lat[d] + 2; k++) begin
            @(negedge clk);
            check($sformatf("%s rdy c%0d", tag, k), 32'(rdy[d]),
                  32'(k == lat[d]));
            check($sformatf("%s din c%0d", tag, k), din[d],
                  (k == lat[d] && !wr) ? rexp : 32'h0);
            if (k == lat[d])
                ctrl[d] = 3'b000;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i]  = 1'b1;
            ctrl[i] = 3'b000;
            addr[i] = '0;
            dout[i] = '0;
        end
        @(negedge clk);
        @(negedge clk);
        check("rst rdy", 32'(rdy[0]), 32'h0);
        check("rst din", din[0], 32'h0);
        check("rst rc", rc0, 32'h0);
        check("rst wc", wc0, 32'h0);
        check("rst sc", sc0, 32'h0);
        check("rst be", 32'(be[0]), 32'h0);
        for (int i = 0; i < 3; i++)
            rst[i] = 1'b0;
        @(negedge clk);

        // Two wait states: write then read back
        access(0, 1'b1, 32'd5, 32'hDEADBEEF, 32'h0, "t1 wr5");
        check("t1 wc", wc0, 32'd1);
        check("t1 sc", sc0, 32'd2);
        check("t1 rc", rc0, 32'd0);
        access(0, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, "t2 rd5");
        check("t2 rc", rc0, 32'd1);
        check("t2 sc", sc0, 32'd4);

        // Zero wait states and address aliasing
        access(1, 1'b1, 32'd0, 32'h11, 32'h0, "t3 wr0");
        access(1, 1'b0, 32'd1024, 32'h0, 32'h11, "t3 rd1024");
        check("t3 wc", wc1, 32'd1);
        check("t3 rc", rc1, 32'd1);
        check("t3 sc", sc1, 32'd0);
        check("t3 be", 32'(be[1]), 32'h0);

        // Conflicting request
        ctrl[0] = 3'b110;
        addr[0] = 32'd5;
        @(negedge clk);
        ctrl[0] = 3'b000;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t4 rdy c%0d", k), 32'(rdy[0]), 32'h0);
            check($sformatf("t4 be c%0d", k), 32'(be[0]), 32'h1);
            @(negedge clk);
        end
        check("t4 rc", rc0, 32'd1);
        check("t4 wc", wc0, 32'd1);
        check("t4 sc", sc0, 32'd4);
        access(0, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, "t4 rd5");
        check("t4 rc2", rc0, 32'd2);
        check("t4 be sticky", 32'(be[0]), 32'h1);

        // Reset during WAIT abandons the write
        access(0, 1'b1, 32'd7, 32'h1234, 32'h0, "t5 wr7");
        check("t5 wc", wc0, 32'd2);
        ctrl[0] = 3'b100;
        addr[0] = 32'd7;
        dout[0] = 32'hAAAA;
        @(negedge clk);
        check("t5 rdy wait", 32'(rdy[0]), 32'h0);
        rst[0]  = 1'b1;
        ctrl[0] = 3'b000;
        #1;
        check("t5 rc", rc0, 32'h0);
        check("t5 wc0", wc0, 32'h0);
        check("t5 sc", sc0, 32'h0);
        check("t5 be", 32'(be[0]), 32'h0);
        @(negedge clk);
        rst[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t5 rdy c%0d", k), 32'(rdy[0]), 32'h0);
            @(negedge clk);
        end
        access(0, 1'b0, 32'd7, 32'h0, 32'h1234, "t5 rd7");
        check("t5 rc1", rc0, 32'd1);
        check("t5 wc1", wc0, 32'd0);

        // Saturation of 4-bit counters
        access(2, 1'b1, 32'd3, 32'h55, 32'h0, "t6 wr3");
        for (int n = 0; n < 17; n++)
            access(2, 1'b0, 32'd3, 32'h0, 32'h55,
                   $sformatf("t6 rd%0d", n));
        check("t6 rc sat", 32'(rc2), 32'd15);
        check("t6 sc sat", 32'(sc2), 32'd15);
        check("t6 wc", 32'(wc2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
